// File: rtl/btn_edit_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Package  : alarm_btn_pkg
// Purpose  : Shared types and helpers for the edit-button conditioner.
// Revision : 1.0
// ============================================================================
package alarm_btn_pkg;

    // ST_HELD is the only non-idle state used when auto-repeat is compiled out.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_HELD   = 2'd3
    } btn_state_t;

    function automatic int ms_to_cycles(input int clk_hz);
        return clk_hz / 1000;
    endfunction

    function automatic int ms_cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_channel.sv
`default_nettype none
// ============================================================================
// Module   : btn_channel
// Purpose  : One button: sync, debounce, press FSM and strobe stretcher.
//            Auto-repeat is built only when BTN_AUTOREPEAT_EN is defined.
// Revision : 1.0
// ============================================================================
module btn_channel
    import alarm_btn_pkg::*;
#(
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int DEBOUNCE_MS     = 20,
    parameter int STRETCH_MS      = 10,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic btn_raw_i,
    output logic btn_edit_o,
    output logic btn_level_o
);

    localparam int c_CNT_W = ms_cnt_width(DEBOUNCE_MS, STRETCH_MS, REPEAT_DELAY_MS, REPEAT_RATE_MS);
    localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_DEB     = c_CNT_W'(DEBOUNCE_MS);
    localparam logic [c_CNT_W-1:0] c_STRETCH = c_CNT_W'(STRETCH_MS);

    logic               w_pressed;
    logic               meta_q, sync_q, level_q;
    logic [c_CNT_W-1:0] deb_cnt_q, stretch_q;
    logic               w_toggle, w_fall, w_fire;
    btn_state_t         state_q, state_d;

    // Inverting ahead of the synchroniser keeps cleared flops meaning "released".
    assign w_pressed = (BTN_ACTIVE_LOW != 0) ? ~btn_raw_i : btn_raw_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= w_pressed;
            sync_q <= meta_q;
        end
    end

    assign w_toggle = (sync_q != level_q) && tick_i && (deb_cnt_q == c_DEB);
    assign w_fall   = w_toggle && level_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
        end else if (sync_q == level_q) begin
            deb_cnt_q <= '0;
        end else if (w_toggle) begin
            deb_cnt_q <= '0;
            level_q   <= ~level_q;
        end else if (tick_i) begin
            deb_cnt_q <= deb_cnt_q + c_ONE;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [c_CNT_W-1:0] c_DELAY = c_CNT_W'(REPEAT_DELAY_MS);
    localparam logic [c_CNT_W-1:0] c_RATE  = c_CNT_W'(REPEAT_RATE_MS);

    logic [c_CNT_W-1:0] rep_q, rep_d;

    always_comb begin
        state_d = state_q;
        rep_d   = rep_q;
        w_fire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (level_q) begin
                    w_fire  = 1'b1;
                    state_d = ST_DELAY;
                    rep_d   = c_DELAY;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                // A release decided this cycle wins over a coincident repeat.
                if (!level_q || w_fall) begin
                    state_d = ST_IDLE;
                    rep_d   = '0;
                end else if (tick_i) begin
                    if (rep_q <= c_ONE) begin
                        w_fire  = 1'b1;
                        state_d = ST_REPEAT;
                        rep_d   = c_RATE;
                    end else begin
                        rep_d = rep_q - c_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                rep_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rep_q   <= '0;
        end else begin
            state_q <= state_d;
            rep_q   <= rep_d;
        end
    end
`else
    always_comb begin
        state_d = state_q;
        w_fire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (level_q) begin
                    w_fire  = 1'b1;
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                if (!level_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stretch_q <= '0;
        end else if (w_fire) begin
            stretch_q <= c_STRETCH;
        end else if (tick_i && (stretch_q != '0)) begin
            stretch_q <= stretch_q - c_ONE;
        end
    end

    assign btn_edit_o  = (stretch_q != '0);
    assign btn_level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/btn_edit_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_edit_conditioner
// Purpose  : Edit-button front end: shared ms tick plus N_BTN channels.
//            Define BTN_AUTOREPEAT_EN to enable hold-to-repeat strobes.
// Revision : 1.0
// ============================================================================
module btn_edit_conditioner
    import alarm_btn_pkg::*;
#(
    parameter int CLK_HZ          = 50000000,
    parameter int N_BTN           = 2,
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int DEBOUNCE_MS     = 20,
    parameter int STRETCH_MS      = 10,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_edit,
    output logic [N_BTN-1:0] btn_level
);

    localparam int c_TICK_DIV = ms_to_cycles(CLK_HZ);
    localparam int c_PRE_W    = (c_TICK_DIV > 1) ? $clog2(c_TICK_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(c_TICK_DIV - 1);
    localparam logic [c_PRE_W-1:0] c_PRE_ONE  = c_PRE_W'(1);

    if (c_TICK_DIV < 1) begin : g_chk_clk
        $error("CLK_HZ must be at least 1000");
    end
    if (DEBOUNCE_MS <= 0 || STRETCH_MS <= 0) begin : g_chk_ms
        $error("DEBOUNCE_MS and STRETCH_MS must be non-zero");
    end
`ifdef BTN_AUTOREPEAT_EN
    if (REPEAT_DELAY_MS <= 0 || REPEAT_RATE_MS <= 0 || STRETCH_MS >= REPEAT_RATE_MS) begin : g_chk_rep
        $error("repeat timing must be non-zero and longer than STRETCH_MS");
    end
`endif

    logic [c_PRE_W-1:0] pre_q;
    logic               w_tick;

    assign w_tick = (pre_q == c_PRE_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       pre_q <= '0;
        else if (w_tick) pre_q <= '0;
        else             pre_q <= pre_q + c_PRE_ONE;
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_channel #(
            .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW),
            .DEBOUNCE_MS    (DEBOUNCE_MS),
            .STRETCH_MS     (STRETCH_MS),
            .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
            .REPEAT_RATE_MS (REPEAT_RATE_MS)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .tick_i     (w_tick),
            .btn_raw_i  (btn_raw[i]),
            .btn_edit_o (btn_edit[i]),
            .btn_level_o(btn_level[i])
        );
    end

endmodule
`default_nettype wire
